// File: rtl/conv_mac_unit.sv
// Multi-cycle signed dot-product responder: four u8 x s8 lanes per beat, summed
// into a saturating 32-bit accumulator and returned with ALU-style flags.
module conv_mac_unit #(
  parameter int MAX_BEATS = 16,
  parameter bit RELU      = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] Result,
  output logic        OverFlow,
  output logic        Zero,
  output logic        Negative
);

  localparam int CNT_W = $clog2(MAX_BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACC, FLUSH, RESP} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    beat_cnt_q;
  logic signed [32:0]  psum_q;
  logic                psum_vld_q;
  logic signed [31:0]  acc_q;
  logic                ovf_q;

  logic signed [18:0]  psum_c;
  logic signed [32:0]  sum_c;
  logic signed [31:0]  sat_c;
  logic                clamp_c;
  logic                beat_hs;
  logic                resp_hs;
  logic                beat_last;

  // Stage 1: unsigned pixel times signed weight, per lane, summed in 19 bits.
  always_comb begin
    psum_c = '0;
    for (int i = 0; i < 4; i++) begin
      psum_c = psum_c + $signed({11'd0, A[8*i +: 8]}) * $signed({{11{B[8*i+7]}}, B[8*i +: 8]});
    end
  end

  // Stage 2: 33-bit add; a mismatch between the top two bits means the
  // 32-bit result would wrap, so clamp toward the sign of the true sum.
  assign sum_c   = {acc_q[31], acc_q} + psum_q;
  assign clamp_c = sum_c[32] ^ sum_c[31];
  assign sat_c   = clamp_c ? (sum_c[32] ? 32'sh8000_0000 : 32'sh7FFF_FFFF) : sum_c[31:0];

  assign beat_hs   = in_valid & in_ready;
  assign resp_hs   = out_valid & out_ready;
  assign beat_last = in_last | (beat_cnt_q == CNT_W'(MAX_BEATS - 1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE, ACC: begin
        in_ready = 1'b1;
        if (in_valid) state_d = beat_last ? FLUSH : ACC;
      end
      // Hold until the last partial sum has landed in the accumulator.
      FLUSH: if (!psum_vld_q) state_d = RESP;
      RESP: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      psum_q     <= '0;
      psum_vld_q <= 1'b0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      psum_vld_q <= beat_hs;
      if (beat_hs) begin
        psum_q     <= {{14{psum_c[18]}}, psum_c};
        beat_cnt_q <= beat_cnt_q + 1'b1;
      end
      if (resp_hs) begin
        acc_q      <= '0;
        ovf_q      <= 1'b0;
        beat_cnt_q <= '0;
      end else if (psum_vld_q) begin
        acc_q <= sat_c;
        if (clamp_c) ovf_q <= 1'b1;
      end
    end
  end

  assign Result   = (RELU && acc_q[31]) ? 32'd0 : acc_q;
  assign Zero     = (Result == 32'd0);
  assign Negative = Result[31];
  assign OverFlow = ovf_q;

endmodule

// File: tb/tb_conv_mac_unit.sv
// Randomized bench for conv_mac_unit: three instances (default, RELU, long
// transactions) checked against an integer dot-product model.
module tb_conv_mac_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid  [3];
  logic        in_last   [3];
  logic        out_ready [3];
  logic [31:0] a_in      [3];
  logic [31:0] b_in      [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        ovf       [3];
  logic        zero      [3];
  logic        neg       [3];
  logic [31:0] result    [3];

  logic [31:0] qa[$];
  logic [31:0] qb[$];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  conv_mac_unit #(.MAX_BEATS(16), .RELU(1'b0)) u_dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_last(in_last[0]),
    .A(a_in[0]), .B(b_in[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .Result(result[0]), .OverFlow(ovf[0]), .Zero(zero[0]), .Negative(neg[0]));

  conv_mac_unit #(.MAX_BEATS(16), .RELU(1'b1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_last(in_last[1]),
    .A(a_in[1]), .B(b_in[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .Result(result[1]), .OverFlow(ovf[1]), .Zero(zero[1]), .Negative(neg[1]));

  conv_mac_unit #(.MAX_BEATS(32768), .RELU(1'b0)) u_dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_last(in_last[2]),
    .A(a_in[2]), .B(b_in[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .Result(result[2]), .OverFlow(ovf[2]), .Zero(zero[2]), .Negative(neg[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int ref_psum(input logic [31:0] a, input logic [31:0] b);
    int s = 0;
    for (int i = 0; i < 4; i++) begin
      s += int'(a[8*i +: 8]) * int'($signed(b[8*i +: 8]));
    end
    return s;
  endfunction

  // Presents one beat from a negedge and returns at the negedge after its handshake.
  task automatic send_beat(input int d, input logic [31:0] av, input logic [31:0] bv, input logic lst);
    int t = 0;
    a_in[d] = av; b_in[d] = bv; in_last[d] = lst; in_valid[d] = 1'b1;
    while (!in_ready[d] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready[d]) begin
      check("beat_accept_timeout", {31'd0, in_ready[d]}, 32'd1);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
    in_valid[d] = 1'b0; in_last[d] = 1'b0;
  endtask

  task automatic check_resp(input int d, input logic [31:0] exp_r, input logic exp_ovf, input int hold);
    int k = 0;
    logic [31:0] held;
    while (!out_valid[d] && k < 10) begin
      check("flush_in_ready", {31'd0, in_ready[d]}, 32'd0);
      @(negedge clk);
      k++;
    end
    check("latency", k, 32'd2);
    if (!out_valid[d]) return;
    check("result", result[d], exp_r);
    check("overflow", {31'd0, ovf[d]}, {31'd0, exp_ovf});
    check("zero", {31'd0, zero[d]}, {31'd0, exp_r == 32'd0});
    check("negative", {31'd0, neg[d]}, {31'd0, exp_r[31]});
    check("resp_in_ready", {31'd0, in_ready[d]}, 32'd0);
    held = result[d];
    repeat (hold) begin
      @(negedge clk);
      check("hold_valid", {31'd0, out_valid[d]}, 32'd1);
      check("hold_result", result[d], held);
      check("hold_in_ready", {31'd0, in_ready[d]}, 32'd0);
    end
    out_ready[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready[d] = 1'b0;
    check("post_valid", {31'd0, out_valid[d]}, 32'd0);
    check("post_in_ready", {31'd0, in_ready[d]}, 32'd1);
  endtask

  // Streams qa/qb into instance d, saturating the model sum after each beat.
  task automatic run_txn(input int d, input bit use_last, input int min_gap, input int max_gap, input int hold);
    longint acc = 0;
    bit     sat = 1'b0;
    int     n   = qa.size();
    longint exp_r;
    for (int i = 0; i < n; i++) begin
      if (i > 0) begin
        repeat (int'($urandom_range(max_gap, min_gap))) begin
          check("gap_in_ready", {31'd0, in_ready[d]}, 32'd1);
          @(negedge clk);
        end
      end
      send_beat(d, qa[i], qb[i], use_last && (i == n - 1));
      acc += ref_psum(qa[i], qb[i]);
      if (acc > 64'sd2147483647) begin acc = 64'sd2147483647; sat = 1'b1; end
      if (acc < -64'sd2147483648) begin acc = -64'sd2147483648; sat = 1'b1; end
    end
    exp_r = (d == 1 && acc < 0) ? 64'sd0 : acc;
    check_resp(d, 32'(exp_r), sat, hold);
    qa.delete();
    qb.delete();
  endtask

  task automatic push(input logic [31:0] av, input logic [31:0] bv);
    qa.push_back(av);
    qb.push_back(bv);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no completion, required finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; in_last[d] = 1'b0; out_ready[d] = 1'b0;
      a_in[d] = '0; b_in[d] = '0;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    for (int d = 0; d < 3; d++) begin
      check("rst_out_valid", {31'd0, out_valid[d]}, 32'd0);
      check("rst_in_ready", {31'd0, in_ready[d]}, 32'd1);
      check("rst_result", result[d], 32'd0);
      check("rst_zero", {31'd0, zero[d]}, 32'd1);
      check("rst_negative", {31'd0, neg[d]}, 32'd0);
      check("rst_overflow", {31'd0, ovf[d]}, 32'd0);
    end

    // Single beat, then signed weights with and without RELU.
    push(32'h0403_0201, 32'h0101_0101); run_txn(0, 1'b1, 0, 0, 0);
    push(32'hFFFF_FFFF, 32'h8080_8080); run_txn(0, 1'b1, 0, 0, 0);
    push(32'hFFFF_FFFF, 32'h8080_8080); run_txn(1, 1'b1, 0, 0, 0);

    // Three beats with two idle cycles between them.
    repeat (3) push(32'h0101_0101, 32'h0202_0202);
    run_txn(0, 1'b1, 2, 2, 0);

    // Backpressure on a zero result.
    push(32'h0000_0005, 32'h0000_0000); run_txn(0, 1'b1, 0, 0, 5);

    // Forced termination at MAX_BEATS without in_last.
    repeat (16) push(32'h0000_0001, 32'h0000_0001);
    run_txn(0, 1'b0, 0, 1, 0);

    // Reset in the middle of a transaction discards it.
    send_beat(0, 32'h0000_0007, 32'h0000_0001, 1'b0);
    send_beat(0, 32'h0000_0007, 32'h0000_0001, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", {31'd0, out_valid[0]}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready[0]}, 32'd1);
    check("midrst_result", result[0], 32'd0);
    check("midrst_zero", {31'd0, zero[0]}, 32'd1);
    push(32'h0000_0003, 32'h0000_0001); run_txn(0, 1'b1, 0, 0, 0);

    // Random transactions on the two short-transaction instances.
    for (int t = 0; t < 24; t++) begin
      int d = t % 2;
      int n = int'($urandom_range(16, 1));
      bit ul = (n < 16) || ($urandom_range(1, 0) == 1);
      for (int i = 0; i < n; i++) push($urandom, $urandom);
      run_txn(d, ul, 0, 2, int'($urandom_range(3, 0)));
    end

    // Long positive stream saturates; the following transaction starts clean.
    repeat (16600) push(32'hFFFF_FFFF, 32'h7F7F_7F7F);
    run_txn(2, 1'b1, 0, 0, 0);
    push($urandom, $urandom); run_txn(2, 1'b1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
    $finish;
  end

endmodule
